param_set_assoc_cache: RTL and testbench
========================================

// Module: param_set_assoc_cache
// PURPOSE
//  Parametrised N-way set-associative, write-back/write-allocate cache with LRU replacement, wrapping its own tag/data arrays.
//  Sits between processor bus (rd/wr/addr/wdata, stall) and a block-wide main-memory port with req/ready handshake.
//  Successor to the fixed 4-way cache top: ways, sets, block words and widths all configurable.
//  Adds dirty-line write-back and a walking flush.
// PARAMETERS
//  WAYS        4    associativity, power of 2, >=2
//  SETS        4    number of sets, power of 2
//  BLK_WORDS   4    words per block, power of 2
//  WORD_W      32   processor/memory word width
//  ADDR_W      10   local word address width; derived OFF_B=clog2(BLK_WORDS), IDX_B=clog2(SETS), TAG_B=ADDR_W-IDX_B-OFF_B
// PORTS
//  clock      in   1              single clock, rising edge
//  reset      in   1              synchronous, active-low
//  addr       in   ADDR_W         word address {tag,index,offset}
//  rd         in   1              read request
//  wr         in   1              write request
//  wdata      in   WORD_W         write data
//  flush      in   1              write back all dirty lines, then invalidate all
//  rdata      out  WORD_W         read data
//  stall      out  1              processor must hold request
//  mem_req    out  1              memory transaction request
//  mem_we     out  1              1=block write-back, 0=block refill
//  mem_addr   out  ADDR_W-OFF_B   block address {tag,index}
//  mem_wdata  out  WORD_W*BLK_WORDS  victim block
//  mem_rdata  in   WORD_W*BLK_WORDS  refill block
//  mem_ready  in   1              one-cycle pulse completing current transaction
// BEHAVIOUR
//  Reset (reset==0 at edge): state IDLE, all valid/dirty=0, LRU age of way w in every set = w; mem_req=0, mem_we=0, rdata=0.
//  States: IDLE, WB, REFILL, FL_SCAN, FL_WB. stall = (state!=IDLE) | ((rd|wr)&~hit) | (flush & state==IDLE).
//  Hit: tag match on valid way, combinational; zero stall. Read: rdata registered, valid cycle after hit.
//  Write hit: word updated, dirty=1 at the edge.
//  Word n occupies block bits [n*WORD_W +: WORD_W]; word 0 = LSBs.
//  rd&wr together: write wins, rdata holds its previous value.
//  Miss in IDLE: victim = lowest-index invalid way, else way with age WAYS-1.
//  Victim valid&dirty -> WB: mem_req=1, mem_we=1, mem_addr={victim tag,index}. Else -> REFILL.
//  WB on mem_ready -> REFILL: mem_req=1, mem_we=0, mem_addr={addr tag,index}.
//  REFILL on mem_ready: install block, valid=1, tag written, dirty=0 -> IDLE.
//  Access then re-evaluates as hit next cycle, stall drops. Miss latency = memory latency(s) + 1 cycle.
//  mem_req, mem_we, mem_addr, mem_wdata registered; stable from assertion until cycle after mem_ready.
//  mem_ready outside WB/REFILL/FL_WB is ignored.
//  Processor holds addr/rd/wr/wdata stable while stall=1; changes during stall are undefined use.
//  LRU per set: accessed way (hit or fill) age->0; ways with age < old age +1; others unchanged. Ages always a permutation 0..WAYS-1.
//  Flush sampled only in IDLE; priority over rd/wr that cycle.
//  FL_SCAN walks line ptr (set,way) 0..SETS*WAYS-1, one line per cycle. Dirty line -> FL_WB; its mem_ready -> resume at next line.
//  After last line: all valid/dirty=0, LRU reset pattern -> IDLE. Clean flush = SETS*WAYS cycles.
//  Reset mid-transaction: mem_req drops at that edge, state IDLE, dirty data discarded. Memory must drop the transaction.
// STRUCTURE
//  Package cache_pkg: state_e enum, clog2-derived localparam functions (OFF_B, IDX_B, TAG_B, BLK_W), line metadata struct {valid,dirty,tag}.
//  Sub-module cache_lru_ages (per-set age array: update on access, victim select, reset init). Tag/data arrays and FSM stay in top.
// TESTING
//  Defaults. Cold read 0x013 -> stall, REFILL req mem_addr=0x04, ready w/ block {D3,D2,D1,D0} -> rdata=D3, 1 cycle after stall drops.
//  Read 0x010..0x013 after fill -> zero stall, rdata D0..D3 each next cycle; no mem_req.
//  Write 0x011=0xDEADBEEF, then fill 4 more tags into set 0 -> LRU victim is tag of 0x010.
//  Victim write-back: mem_we=1, mem_addr=0x04, word1=0xDEADBEEF; then refill.
//  Access order ways 0,1,2,3,0 in set 1, then miss -> way 1 evicted. Ages checked to remain a permutation.
//  Flush with 2 dirty lines -> exactly 2 WB transactions in line order, stall low after 16+2 memory handshakes.
//  Every line then misses.
//  Reset asserted during REFILL with mem_ready withheld -> mem_req=0 next cycle, stall=0, read of prior line misses.

Source files
------------

// File: rtl/param_set_assoc_cache_pkg.sv
// Shared types and width helpers for the parametrised set-associative cache.
// Line metadata keeps a fixed-width tag field; the cache zero-extends its real tag into it.
package cache_pkg;

  localparam int TAG_MAX_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    REFILL,
    FL_SCAN,
    FL_WB
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

  function automatic int off_b(input int blk_words);
    return $clog2(blk_words);
  endfunction

  function automatic int idx_b(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_b(input int addr_w, input int sets, input int blk_words);
    return addr_w - idx_b(sets) - off_b(blk_words);
  endfunction

  function automatic int blk_w(input int word_w, input int blk_words);
    return word_w * blk_words;
  endfunction

endpackage

// File: rtl/param_set_assoc_cache_lru.sv
// Per-set LRU age array: age 0 is most recent, age WAYS-1 is the replacement candidate.
// Victim choice prefers the lowest-index invalid way before falling back to the oldest.
module cache_lru_ages
  import cache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     init,
  input  logic                     access_en,
  input  logic [$clog2(SETS)-1:0]  access_set,
  input  logic [$clog2(WAYS)-1:0]  access_way,
  input  logic [$clog2(SETS)-1:0]  victim_set,
  input  logic [WAYS-1:0]          valid_mask,
  output logic [$clog2(WAYS)-1:0]  victim_way
);

  localparam int WAY_B = $clog2(WAYS);

  logic [WAY_B-1:0] ages [SETS][WAYS];
  logic             found;

  // Ages stay a permutation: only ways younger than the touched way shift up.
  always_ff @(posedge clock) begin
    if (!reset || init) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          ages[s][w] <= WAY_B'(w);
        end
      end
    end else if (access_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_B'(w) == access_way) begin
          ages[access_set][w] <= '0;
        end else if (ages[access_set][w] < ages[access_set][access_way]) begin
          ages[access_set][w] <= ages[access_set][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    victim_way = '0;
    found      = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_mask[w]) begin
        victim_way = WAY_B'(w);
        found      = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages[victim_set][w] == WAY_B'(WAYS - 1)) begin
          victim_way = WAY_B'(w);
        end
      end
    end
  end

endmodule

// File: rtl/param_set_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with LRU replacement and
// a walking flush; block-wide memory port with a req/ready handshake.
module param_set_assoc_cache
  import cache_pkg::*;
#(
  parameter int WAYS      = 4,
  parameter int SETS      = 4,
  parameter int BLK_WORDS = 4,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 10
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [ADDR_W-1:0]                         addr,
  input  logic                                      rd,
  input  logic                                      wr,
  input  logic [WORD_W-1:0]                         wdata,
  input  logic                                      flush,
  output logic [WORD_W-1:0]                         rdata,
  output logic                                      stall,
  output logic                                      mem_req,
  output logic                                      mem_we,
  output logic [ADDR_W-off_b(BLK_WORDS)-1:0]        mem_addr,
  output logic [blk_w(WORD_W, BLK_WORDS)-1:0]       mem_wdata,
  input  logic [blk_w(WORD_W, BLK_WORDS)-1:0]       mem_rdata,
  input  logic                                      mem_ready
);

  localparam int OFF_B  = off_b(BLK_WORDS);
  localparam int IDX_B  = idx_b(SETS);
  localparam int TAG_B  = tag_b(ADDR_W, SETS, BLK_WORDS);
  localparam int BLK_W  = blk_w(WORD_W, BLK_WORDS);
  localparam int WAY_B  = $clog2(WAYS);
  localparam int LINE_B = IDX_B + WAY_B;

  logic [TAG_B-1:0]  a_tag;
  logic [IDX_B-1:0]  a_idx;
  logic [OFF_B-1:0]  a_off;

  state_e            state, state_d;
  line_meta_t        meta [SETS][WAYS];
  logic [BLK_W-1:0]  data [SETS][WAYS];

  logic [WAY_B-1:0]  hit_way, victim_way, victim_q;
  logic [WAYS-1:0]   valid_mask;
  logic              hit;
  logic [LINE_B-1:0] ptr;
  logic [IDX_B-1:0]  ptr_set;
  logic [WAY_B-1:0]  ptr_way;

  logic idle_req, do_hit, do_write, do_read, start_miss, victim_dirty;
  logic start_wb, start_refill, wb_done, refill_done;
  logic start_flush, scan_dirty, fl_wb_done, last_line, advance, flush_done;

  assign a_tag   = addr[ADDR_W-1 -: TAG_B];
  assign a_idx   = addr[OFF_B +: IDX_B];
  assign a_off   = addr[OFF_B-1:0];
  assign ptr_set = ptr[LINE_B-1 -: IDX_B];
  assign ptr_way = ptr[WAY_B-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    valid_mask = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_mask[w] = meta[a_idx][w].valid;
      if (meta[a_idx][w].valid && meta[a_idx][w].tag == TAG_MAX_W'(a_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_B'(w);
      end
    end
  end

  // Flush is only sampled in IDLE and outranks a processor access that cycle.
  assign idle_req     = (state == IDLE) && !flush && (rd || wr);
  assign do_hit       = idle_req && hit;
  assign do_write     = do_hit && wr;
  assign do_read      = do_hit && rd && !wr;
  assign start_miss   = idle_req && !hit;
  assign victim_dirty = meta[a_idx][victim_way].valid && meta[a_idx][victim_way].dirty;
  assign start_wb     = start_miss && victim_dirty;
  assign start_refill = start_miss && !victim_dirty;
  assign wb_done      = (state == WB) && mem_ready;
  assign refill_done  = (state == REFILL) && mem_ready;
  assign start_flush  = (state == IDLE) && flush;
  assign scan_dirty   = (state == FL_SCAN) && meta[ptr_set][ptr_way].valid
                        && meta[ptr_set][ptr_way].dirty;
  assign fl_wb_done   = (state == FL_WB) && mem_ready;
  assign last_line    = (ptr == LINE_B'(SETS * WAYS - 1));
  assign advance      = ((state == FL_SCAN) && !scan_dirty) || fl_wb_done;
  assign flush_done   = advance && last_line;

  assign stall = (state != IDLE) || ((rd || wr) && !hit) || (flush && (state == IDLE));

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start_flush)       state_d = FL_SCAN;
        else if (start_wb)     state_d = WB;
        else if (start_refill) state_d = REFILL;
      end
      WB:      if (mem_ready) state_d = REFILL;
      REFILL:  if (mem_ready) state_d = IDLE;
      FL_SCAN: begin
        if (scan_dirty)     state_d = FL_WB;
        else if (last_line) state_d = IDLE;
      end
      FL_WB:   if (mem_ready) state_d = last_line ? IDLE : FL_SCAN;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      victim_q  <= '0;
      ptr       <= '0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (start_miss) victim_q <= victim_way;

      if (start_flush)                  ptr <= '0;
      else if (advance && !last_line)   ptr <= ptr + 1'b1;

      if (do_read) rdata <= data[a_idx][hit_way][a_off*WORD_W +: WORD_W];

      // Memory-side outputs change only when a transaction starts or completes.
      if (start_wb) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= {meta[a_idx][victim_way].tag[TAG_B-1:0], a_idx};
        mem_wdata <= data[a_idx][victim_way];
      end else if (start_refill || wb_done) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= {a_tag, a_idx};
      end else if (scan_dirty) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= {meta[ptr_set][ptr_way].tag[TAG_B-1:0], ptr_set};
        mem_wdata <= data[ptr_set][ptr_way];
      end else if (refill_done || fl_wb_done) begin
        mem_req   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || flush_done) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          meta[s][w] <= '0;
        end
      end
    end else begin
      if (do_write) meta[a_idx][hit_way].dirty <= 1'b1;
      if (refill_done) begin
        meta[a_idx][victim_q] <= '{valid: 1'b1, dirty: 1'b0, tag: TAG_MAX_W'(a_tag)};
      end
    end
  end

  // NOTE: the data array is not reset; a line's contents are only visible once its valid bit is set.
  always_ff @(posedge clock) begin
    if (do_write)    data[a_idx][hit_way][a_off*WORD_W +: WORD_W] <= wdata;
    if (refill_done) data[a_idx][victim_q] <= mem_rdata;
  end

  cache_lru_ages #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clock      (clock),
    .reset      (reset),
    .init       (flush_done),
    .access_en  (do_hit || refill_done),
    .access_set (a_idx),
    .access_way (refill_done ? victim_q : hit_way),
    .victim_set (a_idx),
    .valid_mask (valid_mask),
    .victim_way (victim_way)
  );

endmodule

// File: tb/tb_param_set_assoc_cache.sv
// Directed bench for param_set_assoc_cache at default parameters; the bench plays main memory
// and checks fills, LRU eviction, dirty write-back, flush and mid-transaction reset.
module tb_param_set_assoc_cache;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         rd = 1'b0, wr = 1'b0, flush = 1'b0, mem_ready = 1'b0;
  logic [9:0]   addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         stall, mem_req, mem_we;
  logic [5:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   req_starts = 0;
  logic req_q = 1'b0;

  param_set_assoc_cache dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .rd        (rd),
    .wr        (wr),
    .wdata     (wdata),
    .flush     (flush),
    .rdata     (rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_req && !req_q) req_starts++;
    req_q = mem_req;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_blk(input logic [9:0] a);
    logic [127:0] b;
    for (int n = 0; n < 4; n++) b[n*32 +: 32] = {16'hA000, a[9:2], 8'(n)};
    return b;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] b, input int off);
    return b[off*32 +: 32];
  endfunction

  // Acts as memory for one transaction: waits for mem_req, checks it, pulses mem_ready.
  task automatic serve(input logic we, input logic [5:0] ma, input logic [127:0] blk,
                       input logic [127:0] wd, input bit chk_wd, input string tag);
    int n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_req"}, mem_req, 1'b1);
    if (mem_req === 1'b1) begin
      check({tag, "_we"}, mem_we, we);
      check({tag, "_addr"}, mem_addr, ma);
      if (chk_wd) check({tag, "_wdata"}, mem_wdata, wd);
      @(negedge clock);
      check({tag, "_hold"}, {mem_req, mem_we, mem_addr}, {1'b1, we, ma});
      mem_ready = 1'b1;
      mem_rdata = blk;
      @(negedge clock);
      mem_ready = 1'b0;
      mem_rdata = '0;
    end
  endtask

  task automatic rd_hit(input logic [9:0] a, input logic [31:0] exp, input string tag);
    addr = a; rd = 1'b1; wr = 1'b0;
    #1 check({tag, "_stall"}, stall, 1'b0);
    @(negedge clock);
    check({tag, "_rdata"}, rdata, exp);
    rd = 1'b0;
  endtask

  task automatic wr_hit(input logic [9:0] a, input logic [31:0] d, input string tag);
    addr = a; wr = 1'b1; rd = 1'b0; wdata = d;
    #1 check({tag, "_stall"}, stall, 1'b0);
    @(negedge clock);
    wr = 1'b0;
  endtask

  task automatic miss(input logic [9:0] a, input bit is_wr, input logic [31:0] d,
                      input bit has_wb, input logic [5:0] wb_a, input logic [127:0] wb_d,
                      input string tag);
    logic [127:0] blk;
    blk = mk_blk(a);
    addr = a; rd = !is_wr; wr = is_wr; wdata = d;
    #1 check({tag, "_stall_miss"}, stall, 1'b1);
    if (has_wb) serve(1'b1, wb_a, '0, wb_d, 1'b1, {tag, "_wb"});
    serve(1'b0, a[9:2], blk, '0, 1'b0, {tag, "_fill"});
    check({tag, "_stall_done"}, stall, 1'b0);
    check({tag, "_req_done"}, mem_req, 1'b0);
    @(negedge clock);
    if (!is_wr) check({tag, "_rdata"}, rdata, word_of(blk, int'(a[1:0])));
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    logic [127:0] exp_blk;
    logic [127:0] exp_blk2;
    int starts0;
    int n;

    repeat (2) @(negedge clock);
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // Cold read: refill of block 0x04, rdata is word 3
    miss(10'h013, 1'b0, '0, 1'b0, '0, '0, "cold");

    for (int i = 0; i < 4; i++) begin
      rd_hit(10'h010 + 10'(i), word_of(mk_blk(10'h010), i), $sformatf("hit%0d", i));
      check($sformatf("hit%0d_noreq", i), mem_req, 1'b0);
    end

    // rd and wr together: write wins, rdata keeps word 3 of the last read
    addr = 10'h011; rd = 1'b1; wr = 1'b1; wdata = 32'hDEADBEEF;
    #1 check("rdwr_stall", stall, 1'b0);
    @(negedge clock);
    check("rdwr_hold", rdata, word_of(mk_blk(10'h010), 3));
    rd = 1'b0; wr = 1'b0;
    rd_hit(10'h011, 32'hDEADBEEF, "rd_after_wr");

    // Fill the rest of set 0, then the LRU victim is the dirty line of tag 1
    miss(10'h020, 1'b0, '0, 1'b0, '0, '0, "s0t2");
    miss(10'h030, 1'b0, '0, 1'b0, '0, '0, "s0t3");
    miss(10'h040, 1'b0, '0, 1'b0, '0, '0, "s0t4");
    exp_blk = mk_blk(10'h010);
    exp_blk[63:32] = 32'hDEADBEEF;
    miss(10'h050, 1'b0, '0, 1'b1, 6'h04, exp_blk, "evict");

    // Set 1: fill ways 0..3, touch 0,1,2,3,0, so way 1 is oldest
    miss(10'h014, 1'b0, '0, 1'b0, '0, '0, "s1t1");
    miss(10'h024, 1'b0, '0, 1'b0, '0, '0, "s1t2");
    miss(10'h034, 1'b0, '0, 1'b0, '0, '0, "s1t3");
    miss(10'h044, 1'b0, '0, 1'b0, '0, '0, "s1t4");
    rd_hit(10'h014, word_of(mk_blk(10'h014), 0), "lru_a0");
    rd_hit(10'h024, word_of(mk_blk(10'h024), 0), "lru_a1");
    rd_hit(10'h034, word_of(mk_blk(10'h034), 0), "lru_a2");
    rd_hit(10'h044, word_of(mk_blk(10'h044), 0), "lru_a3");
    rd_hit(10'h014, word_of(mk_blk(10'h014), 0), "lru_a4");
    check("ages_w0", dut.u_lru.ages[1][0], 2'd0);
    check("ages_w1", dut.u_lru.ages[1][1], 2'd3);
    check("ages_w2", dut.u_lru.ages[1][2], 2'd2);
    check("ages_w3", dut.u_lru.ages[1][3], 2'd1);
    miss(10'h054, 1'b0, '0, 1'b0, '0, '0, "s1t5");
    rd_hit(10'h014, word_of(mk_blk(10'h014), 0), "kept_t1");
    rd_hit(10'h034, word_of(mk_blk(10'h034), 0), "kept_t3");
    rd_hit(10'h044, word_of(mk_blk(10'h044), 0), "kept_t4");
    miss(10'h024, 1'b0, '0, 1'b0, '0, '0, "evicted_t2");

    // Two dirty lines: set 0 way 2 (line 2) and set 2 way 0 (line 8)
    miss(10'h028, 1'b1, 32'hCAFE0028, 1'b0, '0, '0, "wmiss");
    wr_hit(10'h031, 32'h0BADF00D, "whit");

    exp_blk = mk_blk(10'h030);
    exp_blk[63:32] = 32'h0BADF00D;
    exp_blk2 = mk_blk(10'h028);
    exp_blk2[31:0] = 32'hCAFE0028;
    #1 starts0 = req_starts;
    flush = 1'b1;
    #1 check("flush_stall", stall, 1'b1);
    @(negedge clock);
    flush = 1'b0;
    serve(1'b1, 6'h0C, '0, exp_blk, 1'b1, "fl0");
    serve(1'b1, 6'h0A, '0, exp_blk2, 1'b1, "fl1");
    n = 0;
    while (stall !== 1'b0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("flush_end_stall", stall, 1'b0);
    #1 check("flush_wb_count", req_starts - starts0, 2);

    // After flush everything misses, including lines just written back
    miss(10'h031, 1'b0, '0, 1'b0, '0, '0, "post_fl_031");
    miss(10'h028, 1'b0, '0, 1'b0, '0, '0, "post_fl_028");
    miss(10'h014, 1'b0, '0, 1'b0, '0, '0, "post_fl_014");

    // Stray mem_ready while idle has no effect
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    check("stray_ready_req", mem_req, 1'b0);
    rd_hit(10'h014, word_of(mk_blk(10'h014), 0), "stray_ready_hit");

    // Reset while a refill is outstanding
    addr = 10'h060; rd = 1'b1;
    n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("rstmid_req", mem_req, 1'b1);
    check("rstmid_addr", mem_addr, 6'h18);
    reset = 1'b0; rd = 1'b0;
    @(negedge clock);
    check("rstmid_req_drop", mem_req, 1'b0);
    check("rstmid_stall", stall, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    miss(10'h031, 1'b0, '0, 1'b0, '0, '0, "rstmid_miss");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
